// File: rtl/scaled_video_unit.sv
// rtl/scaled_video_unit.sv - VGA scan-out of a scaled, rotated 1-bpp framebuffer with band overlay
module scaled_video_unit #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC_W       = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC_W       = 2,
  parameter int V_BP           = 33,
  parameter int FB_W           = 224,
  parameter int FB_H           = 256,
  parameter int SCALE          = 1,
  parameter int X_OFF          = 208,
  parameter int Y_OFF          = 112,
  parameter int VRAM_BASE      = 'h400,
  parameter int RAM_ADDR_WIDTH = 13,
  parameter int XLEN           = 8,
  parameter int BAND_TOP_END   = 32,
  parameter int BAND_BOT_START = 184,
  parameter logic [11:0] COLOR_TOP = 12'hF00,
  parameter logic [11:0] COLOR_MID = 12'hFFF,
  parameter logic [11:0] COLOR_BOT = 12'h0F0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  input  logic [XLEN-1:0]           ram_data,
  input  logic                      overlay_en,
  output logic [3:0]                vga_red,
  output logic [3:0]                vga_green,
  output logic [3:0]                vga_blue,
  output logic                      h_sync,
  output logic                      v_sync,
  output logic                      mid_irq,
  output logic                      vblank_irq,
  output logic [7:0]                frame_count
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int SW       = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int AW       = RAM_ADDR_WIDTH;
  localparam int COLS     = FB_H / 8;
  localparam int X_END    = (X_OFF + FB_W * SCALE < H_ACTIVE) ? X_OFF + FB_W * SCALE : H_ACTIVE;
  localparam int Y_END    = (Y_OFF + FB_H * SCALE < V_ACTIVE) ? Y_OFF + FB_H * SCALE : V_ACTIVE;
  localparam int HS_ON    = H_ACTIVE + H_FP;
  localparam int HS_OFF   = HS_ON + H_SYNC_W;
  localparam int VS_ON    = V_ACTIVE + V_FP;
  localparam int VS_OFF   = VS_ON + V_SYNC_W;
  localparam int MID_LINE = Y_OFF + (FB_H * SCALE) / 2;
  localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

  logic [HW-1:0] hx_q, hx_d, fx_q, fx_d;
  logic [VW-1:0] vy_q, vy_d, fy_q, fy_d;
  logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic          h_wrap;

  // Framebuffer coordinates track the raster: reload at the window origin, advance every SCALE steps.
  always_comb begin
    h_wrap = int'(hx_q) == H_TOTAL - 1;
    hx_d   = h_wrap ? '0 : hx_q + HW'(1);
    vy_d   = vy_q;
    if (h_wrap) vy_d = (int'(vy_q) == V_TOTAL - 1) ? '0 : vy_q + VW'(1);
    fx_d = fx_q;
    sx_d = sx_q;
    if (int'(hx_d) == X_OFF) begin
      fx_d = '0;
      sx_d = '0;
    end else if (sx_q == S_LAST) begin
      fx_d = fx_q + HW'(1);
      sx_d = '0;
    end else begin
      sx_d = sx_q + SW'(1);
    end
    fy_d = fy_q;
    sy_d = sy_q;
    if (h_wrap) begin
      if (int'(vy_d) == Y_OFF) begin
        fy_d = '0;
        sy_d = '0;
      end else if (sy_q == S_LAST) begin
        fy_d = fy_q + VW'(1);
        sy_d = '0;
      end else begin
        sy_d = sy_q + SW'(1);
      end
    end
  end

  logic          vis0, hs0, vs0, mid0, vb0;
  logic [1:0]    band0;
  logic [AW-1:0] addr0;

  always_comb begin
    vis0  = int'(hx_q) >= X_OFF && int'(hx_q) < X_END && int'(vy_q) >= Y_OFF && int'(vy_q) < Y_END;
    hs0   = !(int'(hx_q) >= HS_ON && int'(hx_q) < HS_OFF);
    vs0   = !(int'(vy_q) >= VS_ON && int'(vy_q) < VS_OFF);
    band0 = 2'd1;
    if (int'(fy_q) < BAND_TOP_END) band0 = 2'd0;
    else if (int'(fy_q) >= BAND_BOT_START) band0 = 2'd2;
    // Columns are stored bottom-up: the last byte of a column holds rows 0..7.
    addr0 = AW'(VRAM_BASE) + AW'(fx_q) * AW'(COLS) + AW'(COLS - 1) - AW'(fy_q >> 3);
    mid0  = hx_q == '0 && int'(vy_q) == MID_LINE;
    vb0   = hx_q == '0 && int'(vy_q) == V_ACTIVE;
  end

  logic [AW-1:0] ram_addr_q;
  logic          vis1_q, vis2_q, hs1_q, hs2_q, vs1_q, vs2_q;
  logic [1:0]    band1_q, band2_q;
  logic [2:0]    bit1_q, bit2_q;
  logic [11:0]   rgb_q, rgb_d, band_col;
  logic          hsync_q, vsync_q, mid_q, vb_q;
  logic [7:0]    fc_q;

  always_comb begin
    case (band2_q)
      2'd0:    band_col = COLOR_TOP;
      2'd2:    band_col = COLOR_BOT;
      default: band_col = COLOR_MID;
    endcase
    rgb_d = 12'h000;
    if (vis2_q && ram_data[~bit2_q]) rgb_d = overlay_en ? band_col : 12'hFFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hx_q       <= '0;
      vy_q       <= '0;
      fx_q       <= '0;
      fy_q       <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      ram_addr_q <= '0;
      vis1_q     <= 1'b0;
      vis2_q     <= 1'b0;
      hs1_q      <= 1'b1;
      hs2_q      <= 1'b1;
      vs1_q      <= 1'b1;
      vs2_q      <= 1'b1;
      band1_q    <= '0;
      band2_q    <= '0;
      bit1_q     <= '0;
      bit2_q     <= '0;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      mid_q      <= 1'b0;
      vb_q       <= 1'b0;
      fc_q       <= '0;
    end else begin
      hx_q    <= hx_d;
      vy_q    <= vy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      // Address only moves for visible pixels, so clipped rows are never fetched.
      if (vis0) ram_addr_q <= addr0;
      vis1_q  <= vis0;
      hs1_q   <= hs0;
      vs1_q   <= vs0;
      band1_q <= band0;
      bit1_q  <= fy_q[2:0];
      vis2_q  <= vis1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      band2_q <= band1_q;
      bit2_q  <= bit1_q;
      rgb_q   <= rgb_d;
      hsync_q <= hs2_q;
      vsync_q <= vs2_q;
      mid_q   <= mid0;
      vb_q    <= vb0;
      if (vb0) fc_q <= fc_q + 8'd1;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign vga_red     = rgb_q[11:8];
  assign vga_green   = rgb_q[7:4];
  assign vga_blue    = rgb_q[3:0];
  assign h_sync      = hsync_q;
  assign v_sync      = vsync_q;
  assign mid_irq     = mid_q;
  assign vblank_irq  = vb_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_scaled_video_unit.sv
// tb/tb_scaled_video_unit.sv - scoreboard bench for scaled_video_unit on a reduced raster
module tb_scaled_video_unit;
  localparam int HA = 40, HF = 4, HSW = 6, HB = 6, HT = HA + HF + HSW + HB;
  localparam int VA = 30, VF = 2, VSW = 2, VB = 3, VT = VA + VF + VSW + VB;
  localparam int FBW = 16, FBH = 16, SC = 2, XO = 10, YO = 4;
  localparam int BASE = 'h400, AW = 13, BTE = 4, BBS = 10;
  localparam logic [11:0] CT = 12'hF00, CM = 12'h00F, CB = 12'h0F0;

  logic clk = 1'b0, rst = 1'b1, overlay_en = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data = 8'h00;
  logic [3:0]    vga_red, vga_green, vga_blue;
  logic          h_sync, v_sync, mid_irq, vblank_irq;
  logic [7:0]    frame_count;

  scaled_video_unit #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC_W(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC_W(VSW), .V_BP(VB),
    .FB_W(FBW), .FB_H(FBH), .SCALE(SC), .X_OFF(XO), .Y_OFF(YO),
    .VRAM_BASE(BASE), .RAM_ADDR_WIDTH(AW), .XLEN(8),
    .BAND_TOP_END(BTE), .BAND_BOT_START(BBS),
    .COLOR_TOP(CT), .COLOR_MID(CM), .COLOR_BOT(CB)
  ) dut (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_data(ram_data), .overlay_en(overlay_en),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .h_sync(h_sync), .v_sync(v_sync), .mid_irq(mid_irq), .vblank_irq(vblank_irq),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) ram_data <= mem[ram_addr];

  typedef struct { int due; logic lit; logic [11:0] band; logic hs; logic vs; } pix_t;
  typedef struct { int due; logic mid; logic vb; logic [7:0] fc; logic [AW-1:0] addr; } ctl_t;
  pix_t pq[$];
  ctl_t cq[$];

  bit   img [FBW][FBH];
  int   errors = 0, checks = 0;
  int   cyc = 0, fc_m = 0, lit_count = 0;
  logic [AW-1:0] last_addr = '0;
  bit   run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // The image is an abstract FBW x FBH bitmap, packed column-major with row 0 in the MSB of a column's last byte.
  task automatic load_image(input int mode);
    for (int a = 0; a < (1 << AW); a++) mem[a] = 8'h00;
    for (int x = 0; x < FBW; x++)
      for (int y = 0; y < FBH; y++) begin
        img[x][y] = (mode == 0) ? 1'($urandom) : (mode == 1) ? 1'b1 : (x == 0 && y == 0);
        mem[BASE + x * (FBH / 8) + (FBH / 8 - 1) - y / 8][7 - y % 8] = img[x][y];
      end
  endtask

  task automatic start_run();
    cyc = 0; fc_m = 0; last_addr = '0; lit_count = 0;
    pq.delete(); cq.delete();
    rst = 1'b0; run = 1'b1;
  endtask

  // Producer: at each edge the raster position held during the ending cycle is consumed.
  initial begin : producer
    int p, hx, vy, fx, fy;
    bit vis;
    pix_t pe;
    ctl_t ce;
    forever begin
      @(posedge clk);
      if (run) begin
        p  = cyc % (HT * VT);
        hx = p % HT;
        vy = p / HT;
        vis = hx < HA && vy < VA && hx >= XO && hx < XO + FBW * SC && vy >= YO && vy < YO + FBH * SC;
        fx = vis ? (hx - XO) / SC : 0;
        fy = vis ? (vy - YO) / SC : 0;
        pe.due  = cyc + 3;
        pe.lit  = vis && img[fx][fy];
        pe.band = (fy < BTE) ? CT : (fy >= BBS) ? CB : CM;
        pe.hs   = !(hx >= HA + HF && hx < HA + HF + HSW);
        pe.vs   = !(vy >= VA + VF && vy < VA + VF + VSW);
        pq.push_back(pe);
        if (vis) last_addr = AW'(BASE + fx * (FBH / 8) + (FBH / 8 - 1) - fy / 8);
        if (hx == 0 && vy == VA) fc_m = (fc_m + 1) % 256;
        ce.due  = cyc + 1;
        ce.mid  = hx == 0 && vy == YO + (FBH * SC) / 2;
        ce.vb   = hx == 0 && vy == VA;
        ce.fc   = 8'(fc_m);
        ce.addr = last_addr;
        cq.push_back(ce);
        cyc = cyc + 1;
      end
    end
  end

  // Monitor: overlay_en seen during the previous cycle selects the colour registered at this cycle's edge.
  initial begin : monitor
    logic [11:0] rgb, e_rgb;
    logic e_hs, e_vs, e_mid, e_vb, ov_prev;
    logic [7:0] e_fc;
    logic [AW-1:0] e_addr;
    pix_t pe;
    ctl_t ce;
    ov_prev = 1'b1;
    forever begin
      @(negedge clk);
      rgb = {vga_red, vga_green, vga_blue};
      if (rst) begin
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_irq", {mid_irq, vblank_irq}, 2'b00);
        chk("rst_sync", {h_sync, v_sync}, 2'b11);
      end else if (run) begin
        e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
        if (pq.size() != 0 && pq[0].due <= cyc) begin
          pe = pq.pop_front();
          chk("pix_slot", pe.due, cyc);
          e_rgb = pe.lit ? (ov_prev ? pe.band : 12'hFFF) : 12'h000;
          e_hs = pe.hs; e_vs = pe.vs;
        end else if (cyc >= 3) begin
          chk("pix_queue_len", pq.size(), 32'd1);
        end
        chk("rgb", rgb, e_rgb);
        chk("h_sync", h_sync, e_hs);
        chk("v_sync", v_sync, e_vs);
        e_mid = 1'b0; e_vb = 1'b0; e_fc = 8'd0; e_addr = '0;
        if (cq.size() != 0 && cq[0].due <= cyc) begin
          ce = cq.pop_front();
          chk("ctl_slot", ce.due, cyc);
          e_mid = ce.mid; e_vb = ce.vb; e_fc = ce.fc; e_addr = ce.addr;
        end else if (cyc >= 1) begin
          chk("ctl_queue_len", cq.size(), 32'd1);
        end
        chk("mid_irq", mid_irq, e_mid);
        chk("vblank_irq", vblank_irq, e_vb);
        chk("frame_count", frame_count, e_fc);
        chk("ram_addr", ram_addr, e_addr);
        if (rgb != 12'h000) lit_count++;
      end
      ov_prev = overlay_en;
    end
  end

  initial begin : stimulus
    int first_low;
    load_image(0);
    repeat (3) @(posedge clk);
    #3;
    chk("rst_frame_count", frame_count, 8'd0);
    chk("rst_ram_addr", ram_addr, '0);
    start_run();
    while (cyc < 2 * HT * VT + 15 * HT + 25) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 31) == 0) overlay_en = ~overlay_en;
    end
    chk("frame_count_two", frame_count, 8'd2);

    #1 rst = 1'b1; run = 1'b0;
    #1;
    chk("async_rgb", {vga_red, vga_green, vga_blue}, 12'h000);
    chk("async_sync", {h_sync, v_sync}, 2'b11);
    chk("async_irq", {mid_irq, vblank_irq}, 2'b00);
    chk("async_frame_count", frame_count, 8'd0);
    chk("async_ram_addr", ram_addr, '0);
    load_image(1);
    overlay_en = 1'b1;
    repeat (5) @(posedge clk);
    #3 start_run();
    first_low = -1;
    for (int i = 0; i < 2 * HT && first_low < 0; i++) begin
      @(negedge clk);
      if (!h_sync) first_low = cyc;
    end
    chk("hsync_first_low", first_low, HA + HF + 3);
    while (cyc < HT * VT) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 15) == 0) overlay_en = ~overlay_en;
    end

    @(posedge clk);
    #3 rst = 1'b1; run = 1'b0;
    load_image(2);
    overlay_en = 1'b1;
    repeat (3) @(posedge clk);
    #3 start_run();
    while (cyc < HT * VT) @(posedge clk);
    @(negedge clk);
    chk("lit_pixels", lit_count, SC * SC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
